// File: rtl/alu_input_capture.sv
// Front-panel capture for the ALU board: synchronises and debounces Enter/Clear and steps
// through operand A, operand B and opcode entry. Define ALU_INPUT_DEBOUNCE_EN to build the debouncers.
module alu_input_capture #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Switches,
  input  logic             EnterBtn,
  input  logic             ClearBtn,
  input  logic             ALUReady,
  output logic [WIDTH-1:0] OperandA,
  output logic [WIDTH-1:0] OperandB,
  output logic [2:0]       OpSel,
  output logic             Valid,
  output logic [1:0]       Stage
);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    ISSUE   = 2'd3
  } stage_e;

  if (WIDTH < 3 || DEBOUNCE_CYCLES < 2) begin : g_invalid_params
    $error("alu_input_capture: WIDTH must be >= 3 and DEBOUNCE_CYCLES >= 2");
  end

  // Bit 0 is Enter, bit 1 is Clear.
  logic [1:0] btn_raw;
  logic [1:0] deb_level;
  logic [1:0] deb_prev_q;
  logic [1:0] press;

  assign btn_raw = {ClearBtn, EnterBtn};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= btn_raw[gi];
        sync2_q <= sync1_q;
      end
    end

`ifdef ALU_INPUT_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             deb_q;

    // The count restarts whenever the synced level agrees, so short glitches never commit.
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        cnt_q <= '0;
        deb_q <= 1'b0;
      end else if (sync2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_q <= '0;
        deb_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign deb_level[gi] = deb_q;
`else
    assign deb_level[gi] = sync2_q;
`endif

    assign press[gi] = deb_level[gi] & ~deb_prev_q[gi];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) deb_prev_q <= 2'b00;
    else       deb_prev_q <= deb_level;
  end

  logic             enter_press;
  logic             clear_press;
  stage_e           stage_q;
  logic [WIDTH-1:0] operand_a_q;
  logic [WIDTH-1:0] operand_b_q;
  logic [2:0]       op_sel_q;
  logic             valid_q;

  assign enter_press = press[0];
  assign clear_press = press[1];

  // Clear is checked first so it beats both Enter and a handshake on the same edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stage_q     <= LOAD_A;
      operand_a_q <= '0;
      operand_b_q <= '0;
      op_sel_q    <= 3'd0;
      valid_q     <= 1'b0;
    end else if (clear_press) begin
      stage_q     <= LOAD_A;
      operand_a_q <= '0;
      operand_b_q <= '0;
      op_sel_q    <= 3'd0;
      valid_q     <= 1'b0;
    end else begin
      case (stage_q)
        LOAD_A: if (enter_press) begin
          operand_a_q <= Switches;
          stage_q     <= LOAD_B;
        end
        LOAD_B: if (enter_press) begin
          operand_b_q <= Switches;
          stage_q     <= LOAD_OP;
        end
        LOAD_OP: if (enter_press) begin
          op_sel_q <= Switches[2:0];
          valid_q  <= 1'b1;
          stage_q  <= ISSUE;
        end
        ISSUE: if (valid_q && ALUReady) begin
          valid_q <= 1'b0;
          stage_q <= LOAD_A;
        end
        default: stage_q <= LOAD_A;
      endcase
    end
  end

  assign OperandA = operand_a_q;
  assign OperandB = operand_b_q;
  assign OpSel    = op_sel_q;
  assign Valid    = valid_q;
  assign Stage    = stage_q;

endmodule

// File: tb/tb_alu_input_capture.sv
// Directed bench for alu_input_capture: capture latency, handshake, glitch rejection,
// Clear priority and mid-operation reset. Adapts latency to ALU_INPUT_DEBOUNCE_EN.
module tb_alu_input_capture;

  localparam int WIDTH = 4;
  localparam int DC    = 4;
`ifdef ALU_INPUT_DEBOUNCE_EN
  localparam int LAT = DC + 2;
`else
  localparam int LAT = 2;
`endif

  logic             Clk;
  logic             Reset;
  logic [WIDTH-1:0] Switches;
  logic             EnterBtn;
  logic             ClearBtn;
  logic             ALUReady;
  logic [WIDTH-1:0] OperandA;
  logic [WIDTH-1:0] OperandB;
  logic [2:0]       OpSel;
  logic             Valid;
  logic [1:0]       Stage;

  int checks   = 0;
  int failures = 0;

  alu_input_capture #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DC)) dut (
    .Clk(Clk), .Reset(Reset), .Switches(Switches), .EnterBtn(EnterBtn),
    .ClearBtn(ClearBtn), .ALUReady(ALUReady), .OperandA(OperandA),
    .OperandB(OperandB), .OpSel(OpSel), .Valid(Valid), .Stage(Stage)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one rising edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] op, input logic v, input logic [1:0] st);
    check({tag, ".A"}, 32'(OperandA), 32'(a));
    check({tag, ".B"}, 32'(OperandB), 32'(b));
    check({tag, ".Op"}, 32'(OpSel), 32'(op));
    check({tag, ".Valid"}, 32'(Valid), 32'(v));
    check({tag, ".Stage"}, 32'(Stage), 32'(st));
  endtask

  // Press Enter long enough to be accepted, then release and let the release settle.
  task automatic enter_press(input logic [3:0] sw);
    Switches = sw;
    EnterBtn = 1'b1;
    repeat (LAT + 1) tick();
    EnterBtn = 1'b0;
    repeat (LAT + 3) tick();
  endtask

  initial begin
    Reset = 1'b1; Switches = '0; EnterBtn = 1'b0; ClearBtn = 1'b0; ALUReady = 1'b0;
    #1;
    check_all("reset", 4'h0, 4'h0, 3'd0, 1'b0, 2'd0);
    repeat (3) tick();
    Reset = 1'b0;
    tick();
    check_all("post_reset", 4'h0, 4'h0, 3'd0, 1'b0, 2'd0);

    // First capture with explicit latency: unchanged after edge LAT-1, captured at edge LAT.
    Switches = 4'h5;
    EnterBtn = 1'b1;
    repeat (LAT) tick();
    check("lat_before.A", 32'(OperandA), 32'h0);
    check("lat_before.Stage", 32'(Stage), 32'd0);
    tick();
    check("lat_at.A", 32'(OperandA), 32'h5);
    check("lat_at.Stage", 32'(Stage), 32'd1);
    EnterBtn = 1'b0;
    repeat (LAT + 3) tick();
    check("held_once.Stage", 32'(Stage), 32'd1);

    enter_press(4'h3);
    check_all("load_b", 4'h5, 4'h3, 3'd0, 1'b0, 2'd2);
    enter_press(4'h2);
    check_all("load_op", 4'h5, 4'h3, 3'd2, 1'b1, 2'd3);

    // Enter in ISSUE is ignored; Valid holds while ALUReady is low.
    enter_press(4'hA);
    check_all("issue_enter_ignored", 4'h5, 4'h3, 3'd2, 1'b1, 2'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("valid_hold%0d", i), 32'(Valid), 32'd1);
    end
    ALUReady = 1'b1;
    tick();
    ALUReady = 1'b0;
    check_all("transfer", 4'h5, 4'h3, 3'd2, 1'b0, 2'd0);

    // ALUReady outside ISSUE changes nothing.
    ALUReady = 1'b1;
    repeat (3) tick();
    ALUReady = 1'b0;
    check_all("ready_idle", 4'h5, 4'h3, 3'd2, 1'b0, 2'd0);

`ifdef ALU_INPUT_DEBOUNCE_EN
    // A 3-clock glitch is shorter than the debounce window.
    Switches = 4'hC;
    EnterBtn = 1'b1;
    repeat (3) tick();
    EnterBtn = 1'b0;
    repeat (LAT + 4) tick();
    check_all("glitch", 4'h5, 4'h3, 3'd2, 1'b0, 2'd0);
`endif

    // Held for 6 clocks: exactly one capture.
    Switches = 4'h9;
    EnterBtn = 1'b1;
    repeat (6) tick();
    EnterBtn = 1'b0;
    repeat (LAT + 6) tick();
    check_all("hold6", 4'h9, 4'h3, 3'd2, 1'b0, 2'd1);

    // Clear and Enter together in LOAD_B: Clear wins.
    Switches = 4'h7;
    EnterBtn = 1'b1;
    ClearBtn = 1'b1;
    repeat (LAT + 1) tick();
    EnterBtn = 1'b0;
    ClearBtn = 1'b0;
    repeat (LAT + 3) tick();
    check_all("clear_enter", 4'h0, 4'h0, 3'd0, 1'b0, 2'd0);

    // Clear in ISSUE on the same edge ALUReady rises: abort, not transfer.
    enter_press(4'h1);
    enter_press(4'h2);
    enter_press(4'h7);
    check_all("reload", 4'h1, 4'h2, 3'd7, 1'b1, 2'd3);
    ClearBtn = 1'b1;
    repeat (LAT) tick();
    check("clear_pending.Valid", 32'(Valid), 32'd1);
    ALUReady = 1'b1;
    tick();
    ALUReady = 1'b0;
    check_all("clear_issue", 4'h0, 4'h0, 3'd0, 1'b0, 2'd0);
    ClearBtn = 1'b0;
    repeat (LAT + 3) tick();

    // Reset asserted mid-cycle takes effect without a clock edge.
    enter_press(4'hE);
    enter_press(4'h6);
    check_all("pre_reset", 4'hE, 4'h6, 3'd0, 1'b0, 2'd2);
    @(posedge Clk);
    #3;
    Reset = 1'b1;
    #1;
    check_all("mid_reset", 4'h0, 4'h0, 3'd0, 1'b0, 2'd0);
    // Enter held through reset is a fresh press once reset releases.
    EnterBtn = 1'b1;
    Switches = 4'hB;
    repeat (2) tick();
    Reset = 1'b0;
    repeat (LAT) tick();
    check("held_reset_early.Stage", 32'(Stage), 32'd0);
    repeat (2) tick();
    check("held_reset.A", 32'(OperandA), 32'hB);
    check("held_reset.Stage", 32'(Stage), 32'd1);
    EnterBtn = 1'b0;
    repeat (LAT + 3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
